// File: rtl/cfeb_frame_rx.sv
// -----------------------------------------------------------------------------
// cfeb_frame_rx
// Receive side of the CFEB SCA readout stream. Splits the incoming 16-bit
// words into frames and checks each frame's length and check word. It also
// decodes the 0xB error-word family: SCA full, LCT FIFO overflow and L1A FIFO
// overflow.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   PUSH              word strobe; DIN, LASTWORD and XCHECK are valid with it
//   DIN[15:0]         stream word
//   LASTWORD          final word of the frame
//   XCHECK            word is the check word (compared, not accumulated)
//   FRAME_DONE        one-cycle pulse in the CLOSE cycle
//   CRC_ERR, LEN_ERR, TMO_ERR   status of the last closed frame (held)
//   SCAFULL, L1P[7:0] SCA-full seen in the current/last frame, its L1A pointer
//   FATAL_LCT/_L1A    sticky FIFO-overflow flags, cleared only by RST
//   ERR_INFO[8:0]     payload of the first fatal word
//   WORD_CNT[9:0]     words accepted in the current or last frame
//   NFRAMES[15:0]     closed-frame counter, wrapping
//   BUSY              frame in progress
//
// Handshake: there is no back-pressure. Every cycle with PUSH=1 consumes
// exactly one word, including the CLOSE cycle, so back-to-back frames lose
// no word.
//
// All state sits in one packed struct. With TMR=1 the struct is held in
// three registers, and a bitwise majority vote selects the working copy.
// The FSM state is the `st` field of that working copy (cur.st).
// -----------------------------------------------------------------------------
module cfeb_frame_rx #(
  parameter bit TMR         = 1'b0,
  parameter int FRAME_WORDS = 97,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PUSH,
  input  logic [15:0] DIN,
  input  logic        LASTWORD,
  input  logic        XCHECK,
  output logic        FRAME_DONE,
  output logic        CRC_ERR,
  output logic        LEN_ERR,
  output logic        TMO_ERR,
  output logic        SCAFULL,
  output logic [7:0]  L1P,
  output logic        FATAL_LCT,
  output logic        FATAL_L1A,
  output logic [8:0]  ERR_INFO,
  output logic [9:0]  WORD_CNT,
  output logic [15:0] NFRAMES,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CLOSE = 2'd2
  } state_t;

  typedef struct packed {
    state_t      st;
    logic [15:0] chk;
    logic [9:0]  word_cnt;
    logic [7:0]  idle_cnt;
    logic        saw_xchk;    // a check word has been seen in this frame
    logic        crc_bad;     // some check word in this frame mismatched
    logic        fatal_frm;   // this frame carried a fatal error word
    logic        crc_err;
    logic        len_err;
    logic        tmo_err;
    logic        scafull;
    logic [7:0]  l1p;
    logic        fatal_lct;
    logic        fatal_l1a;
    logic [8:0]  err_info;
    logic [15:0] nframes;
  } frame_state_t;

  frame_state_t cur;
  frame_state_t nxt;

  // Word decode. A check word is never decoded as an error word.
  logic is_err, is_sca, is_lct, is_l1a;
  assign is_err = PUSH && !XCHECK && (DIN[15:12] == 4'hB);
  assign is_sca = is_err && (DIN[11:9] == 3'b001);
  assign is_lct = is_err && (DIN[11:9] == 3'b100);
  assign is_l1a = is_err && (DIN[11:9] == 3'b010);

  // Per-frame bases. A word pushed outside DATA starts a new frame, so the
  // frame-local fields start from zero instead of their held values.
  logic        start;
  logic [15:0] chk_base;
  logic [9:0]  cnt_base;
  logic        close_now;
  logic        tmo_now;

  always_comb begin
    nxt       = cur;
    start     = PUSH && (cur.st != S_DATA);
    chk_base  = start ? 16'h0000 : cur.chk;
    cnt_base  = start ? 10'd0 : cur.word_cnt;
    close_now = 1'b0;
    tmo_now   = 1'b0;

    // IDLE and CLOSE fall back to IDLE unless a word arrives.
    if (cur.st != S_DATA) nxt.st = S_IDLE;

    if (PUSH) begin
      nxt.word_cnt = (cnt_base == 10'h3FF) ? cnt_base : cnt_base + 10'd1;
      nxt.idle_cnt = 8'd0;
      nxt.saw_xchk = (start ? 1'b0 : cur.saw_xchk) | XCHECK;
      nxt.crc_bad  = (start ? 1'b0 : cur.crc_bad) | (XCHECK && (DIN != chk_base));
      nxt.chk      = XCHECK ? chk_base : ({chk_base[14:0], chk_base[15]} ^ DIN);
      nxt.fatal_frm = (start ? 1'b0 : cur.fatal_frm) | is_lct | is_l1a;
      nxt.scafull  = (start ? 1'b0 : cur.scafull) | is_sca;
      nxt.l1p      = is_sca ? DIN[7:0] : (start ? 8'h00 : cur.l1p);
      if (is_lct) nxt.fatal_lct = 1'b1;
      if (is_l1a) nxt.fatal_l1a = 1'b1;
      // First fatal word wins: the payload is captured only while no fatal
      // flag has been set yet.
      if ((is_lct || is_l1a) && !cur.fatal_lct && !cur.fatal_l1a)
        nxt.err_info = {DIN[8], DIN[7:0]};
      if (LASTWORD) close_now = 1'b1;
      else          nxt.st    = S_DATA;
    end else if (cur.st == S_DATA) begin
      nxt.idle_cnt = cur.idle_cnt + 8'd1;
      if ((cur.idle_cnt + 8'd1) == TIMEOUT[7:0]) begin
        close_now = 1'b1;
        tmo_now   = 1'b1;
      end
    end

    // Status is registered on entry to CLOSE, so it is valid alongside the
    // FRAME_DONE pulse. A fatal frame is not judged on length or check word.
    if (close_now) begin
      nxt.st      = S_CLOSE;
      nxt.tmo_err = tmo_now;
      nxt.crc_err = !nxt.fatal_frm && (nxt.crc_bad || !nxt.saw_xchk);
      nxt.len_err = !nxt.fatal_frm && (nxt.word_cnt != FRAME_WORDS[9:0]);
      nxt.nframes = cur.nframes + 16'd1;
    end
  end

  if (TMR) begin : g_tmr
    frame_state_t rep [3];

    always_ff @(posedge CLK) begin
      for (int i = 0; i < 3; i++) begin
        if (RST) rep[i] <= '0;
        else     rep[i] <= nxt;
      end
    end

    assign cur = frame_state_t'((rep[0] & rep[1]) | (rep[1] & rep[2]) | (rep[0] & rep[2]));
  end else begin : g_single
    frame_state_t rep;

    always_ff @(posedge CLK) begin
      if (RST) rep <= '0;
      else     rep <= nxt;
    end

    assign cur = rep;
  end

  assign FRAME_DONE = (cur.st == S_CLOSE);
  assign BUSY       = (cur.st == S_DATA);
  assign CRC_ERR    = cur.crc_err;
  assign LEN_ERR    = cur.len_err;
  assign TMO_ERR    = cur.tmo_err;
  assign SCAFULL    = cur.scafull;
  assign L1P        = cur.l1p;
  assign FATAL_LCT  = cur.fatal_lct;
  assign FATAL_L1A  = cur.fatal_l1a;
  assign ERR_INFO   = cur.err_info;
  assign WORD_CNT   = cur.word_cnt;
  assign NFRAMES    = cur.nframes;

endmodule

// File: tb/tb_cfeb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_cfeb_frame_rx
// Directed bench for cfeb_frame_rx. Inputs are driven just after the rising
// edge. Outputs are sampled 1 ns after the edge that consumed the word. Each
// single-word frame case is a table record, and the longer corner cases are
// written out as sequences.
// -----------------------------------------------------------------------------
module tb_cfeb_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [15:0] din;
  logic        lastword;
  logic        xcheck;
  logic        frame_done;
  logic        crc_err;
  logic        len_err;
  logic        tmo_err;
  logic        scafull;
  logic [7:0]  l1p;
  logic        fatal_lct;
  logic        fatal_l1a;
  logic [8:0]  err_info;
  logic [9:0]  word_cnt;
  logic [15:0] nframes;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  logic [15:0] fq[$];

  cfeb_frame_rx #(.TMR(1'b0), .FRAME_WORDS(97), .TIMEOUT(255)) dut (
    .CLK(clk), .RST(rst), .PUSH(push), .DIN(din), .LASTWORD(lastword),
    .XCHECK(xcheck), .FRAME_DONE(frame_done), .CRC_ERR(crc_err),
    .LEN_ERR(len_err), .TMO_ERR(tmo_err), .SCAFULL(scafull), .L1P(l1p),
    .FATAL_LCT(fatal_lct), .FATAL_L1A(fatal_l1a), .ERR_INFO(err_info),
    .WORD_CNT(word_cnt), .NFRAMES(nframes), .BUSY(busy)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- driver tasks ----
  task automatic drive(input logic p, input logic [15:0] d, input logic l, input logic x);
    push = p; din = d; lastword = l; xcheck = x;
    @(posedge clk); #1;
    push = 1'b0; lastword = 1'b0; xcheck = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; din = 16'h0; lastword = 1'b0; xcheck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---- scoreboard ----
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference checksum over the words in fq.
  function automatic logic [15:0] chk_q();
    logic [15:0] c = 16'h0000;
    foreach (fq[i]) c = {c[14:0], c[15]} ^ fq[i];
    return c;
  endfunction

  // Push every word in fq, then a check word (optionally corrupted) with LASTWORD.
  task automatic send_fq(input logic [15:0] flip);
    foreach (fq[i]) drive(1'b1, fq[i], 1'b0, 1'b0);
    drive(1'b1, chk_q() ^ flip, 1'b1, 1'b1);
    exp_frames++;
  endtask

  task automatic build_good();
    fq.delete();
    for (int i = 1; i <= 96; i++) fq.push_back(16'(i));
  endtask

  // ---- single-word frame vectors (applied with LASTWORD=1) ----
  typedef struct {
    logic [15:0] din;
    logic        xchk;
    logic        crc;
    logic        len;
    logic        sca;
    logic [7:0]  l1p;
    logic        lct;
    logic        l1a;
    logic [8:0]  info;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'hB937, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'h137}; // LCT overflow
    vecs[1] = '{16'hB4FF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9'h137}; // L1A, info kept
    vecs[2] = '{16'hB3A5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 9'h137}; // SCA full, no check
    vecs[3] = '{16'h8123, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 9'h137}; // bit15 data
    vecs[4] = '{16'hB600, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 9'h137}; // type 011 = data
    vecs[5] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 9'h137}; // check word matches 0
    vecs[6] = '{16'hB937, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 9'h137}; // check word, not decoded
    vecs[7] = '{16'hB2C4, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC4, 1'b1, 1'b1, 9'h137}; // SCA full via B2xx

    do_reset();

    // Reset state
    check("rst frame_done", frame_done, 0);
    check("rst busy", busy, 0);
    check("rst word_cnt", word_cnt, 0);
    check("rst nframes", nframes, 0);
    check("rst status", {crc_err, len_err, tmo_err, scafull, fatal_lct, fatal_l1a}, 0);
    check("rst l1p/info", {l1p, err_info}, 0);

    // Good frame
    build_good();
    foreach (fq[i]) drive(1'b1, fq[i], 1'b0, 1'b0);
    check("good pre-close frame_done", frame_done, 0);
    check("good pre-close busy", busy, 1);
    check("good pre-close word_cnt", word_cnt, 96);
    drive(1'b1, chk_q(), 1'b1, 1'b1);
    exp_frames++;
    check("good frame_done", frame_done, 1);
    check("good busy", busy, 0);
    check("good crc_err", crc_err, 0);
    check("good len_err", len_err, 0);
    check("good word_cnt", word_cnt, 97);
    check("good nframes", nframes, 1);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("good pulse width", frame_done, 0);
    check("good status held", {crc_err, len_err, word_cnt}, {2'b00, 10'd97});

    // Check word bit0 flipped
    build_good();
    send_fq(16'h0001);
    check("badchk crc_err", crc_err, 1);
    check("badchk len_err", len_err, 0);
    check("badchk nframes", nframes, 16'(exp_frames));

    // One data word dropped, check word consistent with what was sent
    build_good();
    fq.delete(40);
    send_fq(16'h0000);
    check("short len_err", len_err, 1);
    check("short crc_err", crc_err, 0);
    check("short word_cnt", word_cnt, 96);

    // SCA-full word mid-frame
    build_good();
    fq[47] = 16'hB3A5;
    send_fq(16'h0000);
    check("sca scafull", scafull, 1);
    check("sca l1p", l1p, 8'hA5);
    check("sca crc_err", crc_err, 0);
    check("sca len_err", len_err, 0);
    check("sca no fatal", {fatal_lct, fatal_l1a}, 0);
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    check("sca cleared at start", {scafull, l1p}, 0);
    check("start word_cnt", word_cnt, 1);
    drive(1'b1, 16'h0001, 1'b1, 1'b1);   // check of a one-word body is the word itself
    exp_frames++;
    check("two-word crc_err", crc_err, 0);
    check("two-word len_err", len_err, 1);

    // Single-word frames, table-driven
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].din, 1'b1, vecs[i].xchk);
      exp_frames++;
      check($sformatf("vec%0d frame_done", i), frame_done, 1);
      check($sformatf("vec%0d crc_err", i), crc_err, vecs[i].crc);
      check($sformatf("vec%0d len_err", i), len_err, vecs[i].len);
      check($sformatf("vec%0d scafull/l1p", i), {scafull, l1p}, {vecs[i].sca, vecs[i].l1p});
      check($sformatf("vec%0d fatal", i), {fatal_lct, fatal_l1a}, {vecs[i].lct, vecs[i].l1a});
      check($sformatf("vec%0d err_info", i), err_info, vecs[i].info);
      check($sformatf("vec%0d word_cnt", i), word_cnt, 1);
      check($sformatf("vec%0d nframes", i), nframes, 16'(exp_frames));
    end

    // Fatal flags survive good frames
    for (int k = 0; k < 3; k++) begin
      build_good();
      send_fq(16'h0000);
      check($sformatf("sticky%0d crc_err", k), crc_err, 0);
      check($sformatf("sticky%0d fatal", k), {fatal_lct, fatal_l1a, err_info}, {2'b11, 9'h137});
    end

    do_reset();
    check("rst clears fatal", {fatal_lct, fatal_l1a, err_info}, 0);
    check("rst clears nframes", nframes, 0);

    // Timeout: 10 words then silence
    for (int i = 1; i <= 10; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
    begin
      int n = 0;
      while (!frame_done && n < 400) begin
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        n++;
      end
      check("tmo wait cycles", n, 255);
    end
    check("tmo frame_done", frame_done, 1);
    check("tmo tmo_err", tmo_err, 1);
    check("tmo word_cnt", word_cnt, 10);
    check("tmo len/crc", {len_err, crc_err}, 2'b11);
    check("tmo nframes", nframes, 1);
    drive(1'b1, 16'h0001, 1'b0, 1'b0);   // pushed during the CLOSE cycle
    check("close push word_cnt", word_cnt, 1);
    check("close push busy", busy, 1);
    check("close push frame_done", frame_done, 0);
    drive(1'b1, 16'h0001, 1'b1, 1'b1);
    check("after tmo tmo_err", tmo_err, 0);
    check("after tmo word_cnt", word_cnt, 2);

    // RST on word 50
    do_reset();
    for (int i = 1; i <= 49; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
    check("pre-rst busy", busy, 1);
    rst = 1'b1;
    drive(1'b1, 16'd50, 1'b0, 1'b0);
    rst = 1'b0;
    check("midrst frame_done", frame_done, 0);
    check("midrst busy", busy, 0);
    check("midrst counts", {word_cnt, nframes}, 0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    check("midrst no pulse", frame_done, 0);

    // NFRAMES wrap with back-to-back one-word frames
    do_reset();
    for (int i = 0; i < 65535; i++) drive(1'b1, 16'h0001, 1'b1, 1'b0);
    check("wrap preload", nframes, 16'hFFFF);
    check("wrap b2b word_cnt", word_cnt, 1);
    drive(1'b1, 16'h0001, 1'b1, 1'b0);
    check("wrap nframes", nframes, 16'h0000);
    check("wrap frame_done", frame_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
